serial_word_receiver: RTL and testbench
=======================================

# serial_word_receiver

Serial-in, parallel-out receiver that is the far end of the team's load/shift-right serializer. That serializer shifts its word out LSB-first, one bit per `shift` cycle, on its bit-0 line. This block samples those bits on strobed clock edges and rebuilds the word in a shift register that shifts right. It presents each completed word on a double-buffered output with a valid/ready handshake. It sits between the serial link and the consuming datapath.

## Interface
- `WIDTH`, default 4: data bits per frame, ≥ 2.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `ser_in`  input  1  serial data bit, LSB first.
- `ser_valid`  input  1  `ser_in` is sampled on this edge; mirrors the serializer's `shift` select.
- `data_out`  output  WIDTH  last completed word.
- `out_valid`  output  1  `data_out` holds an unconsumed word.
- `out_ready`  input  1  consumer accepts `data_out` on an edge where `out_valid` is 1.
- `busy`  output  1  partial frame in progress (state ≠ IDLE).
- `overrun`  output  1  sticky; a completed word was dropped.
- `parity_err`  output  1  sticky; parity mismatch seen (tied 0 without the macro).

## Operation
- Reset values: `data_out`=0, `out_valid`=0, `busy`=0, `overrun`=0, `parity_err`=0. Shift register=0, bit counter=0, state=IDLE.
- FSM states: IDLE, DATA, PAR (PAR exists only with the macro).
- IDLE + `ser_valid`: shift bit in and go to DATA with count=1. Without `ser_valid`: hold.
- Each sampled bit: `shreg <= {ser_in, shreg[WIDTH-1:1]}`. After WIDTH bits the first bit received is in `shreg[0]`.
- DATA + `ser_valid`: shift bit in and increment count. On the WIDTH-th bit:
  - without the macro: complete the frame and go to IDLE;
  - with the macro: go to PAR.
- PAR + `ser_valid`: check parity, complete the frame, go to IDLE.
- Edges without `ser_valid` change nothing: no shift, no count, no state change, no timeout.
- Frame completion, when `out_valid`=0 or `out_ready`=1 on the same edge: `data_out` <= assembled word, `out_valid` <= 1.
- Frame completion, when `out_valid`=1 and `out_ready`=0: the new word is discarded, `overrun` <= 1, and `data_out` keeps the old word.
- Handshake without a completion on the same edge: `out_valid`=1 and `out_ready`=1 clears `out_valid`.
- `out_ready` while `out_valid`=0 is ignored.
- Reception continues while `out_valid` is held, giving one frame of buffering.
- `overrun` and `parity_err` clear only on `rst`.
- `rst` mid-frame discards the partial frame and any held word immediately, without waiting for a clock edge.

## Timing
- The bit is sampled on the rising edge where `ser_valid`=1.
- `data_out`/`out_valid` update on the same edge that samples the final bit of the frame, i.e. zero added cycles of latency.
- Back-to-back frames are allowed: the first bit of the next frame may arrive on the edge after completion.
- Consumer handshake takes one edge. `out_valid` falls on the edge after it is accepted, unless a new word loads on that same edge.
- All outputs are registered; no combinational input→output paths.

## Configuration
- `SERIAL_WORD_RECEIVER_PARITY_EN` defined:
  - frame = WIDTH data bits + 1 even-parity bit, with the XOR of all WIDTH+1 bits required to be 0;
  - on mismatch `parity_err` <= 1 and the word is still delivered.
- Not defined:
  - frame = WIDTH bits and the PAR state is absent;
  - `parity_err` is constant 0.

## Structure
- Shared package holds:
  - FSM state enum `rx_state_t` (IDLE, DATA, PAR);
  - `RX_CNT_W = $clog2(WIDTH+1)`.
- One natural sub-module: `rx_out_buffer`. It owns `data_out`/`out_valid`, the handshake and `overrun`. The top level keeps the shift register, counter, FSM and parity.

## Test plan
- Reset then idle: `rst` pulse and 10 edges with `ser_valid`=0 → all outputs 0, `busy`=0.
- Single frame, WIDTH=4, no macro: bits 1,1,0,1 on consecutive strobes → after the 4th edge `data_out`=4'b1011 and `out_valid`=1; with `out_ready`=1 one edge later, `out_valid`=0.
- Gapped strobes: same bits with 3 idle edges between each → identical result; `busy`=1 throughout the frame.
- Overrun: `out_ready`=0, send 4'b1011 then 4'b0110 → `data_out`=4'b1011, `overrun`=1. Repeat with `out_ready` raised on the completion edge → `data_out`=4'b0110, `overrun`=0.
- Reset mid-frame: send 2 bits, assert `rst`, then send 4'b0101 → `data_out`=4'b0101, not a mix with the partial bits.
- Macro defined: send 4'b1011 + parity 1 → `parity_err`=0. Send 4'b1011 + parity 0 → `data_out`=4'b1011, `parity_err`=1.

Source files
------------

// File: rtl/serial_word_receiver_pkg.sv
// Shared types and sizing helpers for the serial word receiver.
// The frame counter width follows the data width of each instance.
package serial_word_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } rx_state_t;

    localparam int RX_WIDTH_DEFAULT = 4;
    localparam int RX_CNT_W         = $clog2(RX_WIDTH_DEFAULT + 1);

    // Counter width for an arbitrary data width (must hold 0..WIDTH).
    function automatic int rx_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_receiver_out_buffer.sv
// Holding register for completed words: valid/ready handshake plus a
// sticky overrun flag raised when a word arrives with nowhere to go.
module rx_out_buffer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             overrun
);

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (load) begin
            if (!out_valid || out_ready) begin
                data_out  <= word;
                out_valid <= 1'b1;
            end else begin
                // Slot still owned by the consumer: the new word is lost.
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-in, parallel-out receiver for an LSB-first serial link.
// Define SERIAL_WORD_RECEIVER_PARITY_EN to add a trailing even-parity bit.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH = RX_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CNT_W = rx_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    rx_state_t        state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next, shifted, word;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             frame_done;
    logic             busy_q;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    logic             par_bad;
    logic             parity_q;
`endif

    assign shifted = {ser_in, shreg[WIDTH-1:1]};

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        frame_done = 1'b0;
        word       = shreg;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        par_bad    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (ser_valid) begin
                    shreg_next = shifted;
                    cnt_next   = CNT_W'(1);
                    state_next = DATA;
                end
            end
            DATA: begin
                if (ser_valid) begin
                    shreg_next = shifted;
                    if (cnt == LAST_IDX) begin
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                        cnt_next   = cnt + CNT_W'(1);
                        state_next = PAR;
`else
                        cnt_next   = '0;
                        state_next = IDLE;
                        frame_done = 1'b1;
                        word       = shifted;
`endif
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            PAR: begin
                // Even parity: data bits and parity bit must XOR to zero.
                if (ser_valid) begin
                    frame_done = 1'b1;
                    word       = shreg;
                    par_bad    = ^{ser_in, shreg};
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            shreg  <= shreg_next;
            cnt    <= cnt_next;
            busy_q <= (state_next != IDLE);
        end
    end

    assign busy = busy_q;

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (par_bad) begin
            parity_q <= 1'b1;
        end
    end

    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

    rx_out_buffer #(
        .WIDTH (WIDTH)
    ) u_out_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (frame_done),
        .word      (word),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver (WIDTH=4), with or without
// SERIAL_WORD_RECEIVER_PARITY_EN; expected words flow through a scoreboard queue.
module tb_serial_word_receiver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ser_in = 1'b0;
    logic         ser_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    typedef struct {
        logic [W-1:0] word;      // bit 0 is transmitted first
        int           gap;       // idle edges between strobes
        logic [W-1:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
    endtask

    // Send one frame; out_ready is forced high on the final edge when ready_last=1.
    task automatic send_frame(input logic [W-1:0] word, input int gap,
                              input logic ready_last, input logic par_flip);
        logic [W:0] frame;
        int         nbits;
        logic       saved;
        frame = {(^word) ^ par_flip, word};
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        nbits = W + 1;
`else
        nbits = W;
`endif
        for (int i = 0; i < nbits; i++) begin
            saved     = out_ready;
            ser_valid = 1'b1;
            ser_in    = frame[i];
            if (i == nbits - 1 && ready_last) out_ready = 1'b1;
            tick();
            ser_valid = 1'b0;
            ser_in    = 1'b0;
            out_ready = saved;
            if (i < nbits - 1) begin
                check("busy_mid_frame", {31'b0, busy}, 32'd1);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("busy_gap", {31'b0, busy}, 32'd1);
                end
            end else begin
                check("busy_after_frame", {31'b0, busy}, 32'd0);
            end
        end
    endtask

    task automatic expect_word(input string name);
        logic [W-1:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, data_out=0x%0h", name, data_out);
        end else begin
            exp = exp_q.pop_front();
            check(name, {28'b0, data_out}, {28'b0, exp});
            check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{word: 4'b1011, gap: 0, exp_data: 4'b1011};
        vecs[1] = '{word: 4'b1011, gap: 3, exp_data: 4'b1011};
        vecs[2] = '{word: 4'b0000, gap: 1, exp_data: 4'b0000};
        vecs[3] = '{word: 4'b1111, gap: 0, exp_data: 4'b1111};
        vecs[4] = '{word: 4'b0110, gap: 2, exp_data: 4'b0110};
        vecs[5] = '{word: 4'b1000, gap: 0, exp_data: 4'b1000};

        // Reset then idle
        #2;
        rst = 1'b0;
        repeat (10) tick();
        check("reset_data_out", {28'b0, data_out}, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_overrun", {31'b0, overrun}, 32'd0);
        check("reset_parity_err", {31'b0, parity_err}, 32'd0);

        // Table-driven frames, each drained with a one-edge handshake
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(vecs[v].exp_data);
            send_frame(vecs[v].word, vecs[v].gap, 1'b0, 1'b0);
            expect_word("table_data");
            out_ready = 1'b1;
            tick();
            check("table_drain", {31'b0, out_valid}, 32'd0);
            tick();
            check("ready_while_empty", {31'b0, out_valid}, 32'd0);
            out_ready = 1'b0;
        end
        check("table_no_overrun", {31'b0, overrun}, 32'd0);

        // A few random words
        for (int r = 0; r < 4; r++) begin
            logic [W-1:0] rw;
            rw = W'($urandom_range(0, (1 << W) - 1));
            exp_q.push_back(rw);
            send_frame(rw, r % 2, 1'b0, 1'b0);
            expect_word("random_data");
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Overrun: second word dropped while the first is held
        do_reset();
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 0, 1'b0, 1'b0);
        send_frame(4'b0110, 0, 1'b0, 1'b0);
        expect_word("overrun_keeps_old");
        check("overrun_set", {31'b0, overrun}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("overrun_sticky", {31'b0, overrun}, 32'd1);

        // Ready raised on the completion edge: new word replaces the old one
        do_reset();
        check("overrun_cleared_by_rst", {31'b0, overrun}, 32'd0);
        send_frame(4'b1011, 0, 1'b0, 1'b0);
        exp_q.push_back(4'b0110);
        send_frame(4'b0110, 0, 1'b1, 1'b0);
        expect_word("ready_on_completion");
        check("no_overrun_with_ready", {31'b0, overrun}, 32'd0);

        // Back-to-back frames with the consumer always ready
        do_reset();
        out_ready = 1'b1;
        exp_q.push_back(4'b1100);
        send_frame(4'b1100, 0, 1'b1, 1'b0);
        expect_word("b2b_first");
        exp_q.push_back(4'b0011);
        send_frame(4'b0011, 0, 1'b1, 1'b0);
        expect_word("b2b_second");
        out_ready = 1'b0;
        check("b2b_no_overrun", {31'b0, overrun}, 32'd0);

        // Reset mid-frame with a word held: both are discarded immediately
        do_reset();
        exp_q.push_back(4'b1111);
        send_frame(4'b1111, 0, 1'b0, 1'b0);
        expect_word("held_before_rst");
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        tick();
        tick();
        ser_valid = 1'b0;
        check("busy_before_rst", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_busy", {31'b0, busy}, 32'd0);
        check("rst_async_valid", {31'b0, out_valid}, 32'd0);
        check("rst_async_data", {28'b0, data_out}, 32'd0);
        #1;
        rst = 1'b0;
        exp_q.push_back(4'b0101);
        send_frame(4'b0101, 0, 1'b0, 1'b0);
        expect_word("after_mid_rst");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        // Parity: good parity bit, then a corrupted one
        do_reset();
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 0, 1'b1, 1'b0);
        expect_word("parity_good_data");
        check("parity_good", {31'b0, parity_err}, 32'd0);
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 1, 1'b1, 1'b1);
        expect_word("parity_bad_data");
        check("parity_bad", {31'b0, parity_err}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("parity_sticky", {31'b0, parity_err}, 32'd1);
`else
        check("parity_err_tied_low", {31'b0, parity_err}, 32'd0);
`endif

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: %0d words expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
